// File: rtl/tx_symbol_gen.sv
// PRBS9-driven PAM2/PAM4 symbol source with zero-insertion upsampling by OS.
// After a stop, it emits FLUSH_LEN zero samples so the downstream FIR can drain.
module tx_symbol_gen #(
   parameter int         W         = 9,
   parameter int         DATA_F    = 7,
   parameter int         OS        = 4,
   parameter int         AMP       = 32,
   parameter logic [8:0] SEED      = 9'h1FF,
   parameter int         FLUSH_LEN = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                stop,
   input  logic                pam4_sel,
   output logic signed [W-1:0] dout,
   output logic                sym_strobe,
   output logic                busy
);

   localparam int PW = $clog2(OS);
   localparam int FW = $clog2(FLUSH_LEN + 1);
   localparam logic signed [W-1:0] L3 = W'(3 * AMP);
   localparam logic signed [W-1:0] L1 = W'(AMP);

   if (3 * AMP > 2 ** (W - 1) - 1) begin : g_amp_chk
      $error("tx_symbol_gen: 3*AMP does not fit in signed W bits");
   end
   if (SEED == 9'd0) begin : g_seed_chk
      $error("tx_symbol_gen: SEED must be nonzero");
   end
   if (OS < 2 || OS > 16) begin : g_os_chk
      $error("tx_symbol_gen: OS must be in 2..16");
   end
   if (FLUSH_LEN < 1) begin : g_flush_chk
      $error("tx_symbol_gen: FLUSH_LEN must be at least 1");
   end
   if (DATA_F >= W) begin : g_frac_chk
      $error("tx_symbol_gen: DATA_F must be smaller than W");
   end

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t                state, state_nx;
   logic [PW-1:0]         phase, phase_nx;
   logic [FW-1:0]         flush_cnt, flush_nx;
   logic                  mode, mode_nx;
   logic [8:0]            prbs, prbs_nx;
   logic signed [W-1:0]   dout_nx;
   logic                  strobe_nx;
   logic                  busy_nx;

   logic [8:0]            prbs_src;
   logic [8:0]            prbs_one;
   logic [8:0]            prbs_two;
   logic                  bit_hi;
   logic                  bit_lo;
   logic signed [W-1:0]   sym_level;

   function automatic logic [8:0] prbs_step(input logic [8:0] s);
      return {s[7:0], s[8] ^ s[4]};
   endfunction

   // An all-zero LFSR is stuck forever, so substitute SEED before stepping.
   assign prbs_src = (prbs == 9'd0) ? SEED : prbs;
   assign prbs_one = prbs_step(prbs_src);
   assign prbs_two = prbs_step(prbs_one);
   assign bit_hi   = prbs_one[0];
   assign bit_lo   = prbs_two[0];

   always_comb begin
      sym_level = -L3;
      if (!mode) begin
         sym_level = bit_hi ? L3 : -L3;
      end else begin
         case ({bit_hi, bit_lo})
            2'b00:   sym_level = -L3;
            2'b01:   sym_level = -L1;
            2'b11:   sym_level = L1;
            default: sym_level = L3;
         endcase
      end
   end

   always_comb begin
      state_nx  = state;
      phase_nx  = phase;
      flush_nx  = flush_cnt;
      mode_nx   = mode;
      prbs_nx   = prbs;
      dout_nx   = '0;
      strobe_nx = 1'b0;
      case (state)
         IDLE: begin
            if (start && !stop) begin
               state_nx = RUN;
               phase_nx = '0;
               mode_nx  = pam4_sel;
            end
         end
         RUN: begin
            // stop wins over a pending phase-0 symbol and leaves the PRBS untouched
            if (stop) begin
               state_nx = FLUSH;
               flush_nx = '0;
               phase_nx = '0;
            end else begin
               if (phase == '0) begin
                  dout_nx   = sym_level;
                  strobe_nx = 1'b1;
                  prbs_nx   = mode ? prbs_two : prbs_one;
               end
               phase_nx = (phase == PW'(OS - 1)) ? '0 : phase + PW'(1);
            end
         end
         FLUSH: begin
            if (flush_cnt == FW'(FLUSH_LEN - 1)) begin
               state_nx = IDLE;
               flush_nx = '0;
            end else begin
               flush_nx = flush_cnt + FW'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
      busy_nx = (state_nx != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         phase      <= '0;
         flush_cnt  <= '0;
         mode       <= 1'b0;
         prbs       <= SEED;
         dout       <= '0;
         sym_strobe <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nx;
         phase      <= phase_nx;
         flush_cnt  <= flush_nx;
         mode       <= mode_nx;
         prbs       <= prbs_nx;
         dout       <= dout_nx;
         sym_strobe <= strobe_nx;
         busy       <= busy_nx;
      end
   end

endmodule
